debounce_scan_controller: RTL and testbench
===========================================

// Module: debounce_scan_controller
// PURPOSE
//  Time-shared debounce engine for CHANNELS slow inputs (switches, limit sensors).
//  - A prescaler issues a scan tick; a scan FSM visits one channel per clock.
//  - Each visit shifts that channel's history and updates its debounced level.
//  - Each debounced edge is pushed as an event into a valid/ready FIFO read by the host CPU/control logic.
// PARAMETERS
//  CHANNELS         8        number of input channels (2..32)
//  DEPTH            4        history samples per channel (>=2); level changes only on DEPTH equal samples
//  CLOCK_PERIOD_NS  20       Clock period
//  FILTER_PERIOD_NS 500_000  nominal settle time; PRESCALE = FILTER_PERIOD_NS/CLOCK_PERIOD_NS/(DEPTH-1)
//  FIFO_DEPTH       8        event FIFO entries (power of 2)
// PORTS
//  Clock          in   1         system clock
//  nReset         in   1         asynchronous active-low reset
//  Enable         in   1         scanning allowed
//  I              in   CHANNELS  raw inputs, already synchronised upstream
//  O              out  CHANNELS  debounced levels
//  EventValid     out  1         FIFO head valid
//  EventReady     in   1         consumer accepts head
//  EventChannel   out  $clog2(CHANNELS)  channel of head event
//  EventRise      out  1         1 = rising edge, 0 = falling edge
//  Overflow       out  1         sticky: an event was dropped
//  ClearOverflow  in   1         clears Overflow
// BEHAVIOUR
//  Reset values: O='1, all histories='1, FIFO empty (EventValid=0), Overflow=0, FSM=IDLE, prescaler=0.
//  Prescaler: counts 0..PRESCALE-1 while Enable=1 and emits a 1-cycle Tick at wrap. It holds its value while Enable=0.
//  Static check: elaboration fails if PRESCALE <= CHANNELS, so a tick can never land inside a scan.
//  FSM:
//   - IDLE -> SCAN on Tick, with Ch=0.
//   - In SCAN, Ch increments every cycle; SCAN -> IDLE after Ch=CHANNELS-1.
//   - If Enable drops mid-scan, the current pass completes.
//  SCAN cycle for channel c, sampled at the clock edge:
//   - Hnew = {H[c][DEPTH-2:0], I[c]}, and H[c] <= Hnew.
//   - If Hnew=='0 and O[c]==1: O[c] <= 0 and push {c, fall}.
//   - If Hnew=='1 and O[c]==0: O[c] <= 1 and push {c, rise}.
//   - Otherwise there is no change.
//   - O[c] and the push happen on the same edge, so EventValid is visible the cycle after the visit.
//  FIFO:
//   - Pop when EventValid && EventReady.
//   - Push while full and not popping: the event is dropped, Overflow <= 1, and O still updates.
//   - Push and pop in the same cycle while full: both succeed with no drop.
//   - Head outputs are stable while EventValid=1 and EventReady=0.
//   - Pointers wrap modulo FIFO_DEPTH; occupancy uses an extra pointer bit.
//  Overflow: set has priority over ClearOverflow in the same cycle.
//  Reset mid-scan or mid-handshake: all state returns to the reset values immediately; pending events are lost.
//  Channel order is fixed 0..CHANNELS-1, so simultaneous edges are queued in ascending channel order.
// CONFIGURATION
//  DEBOUNCE_TIMESTAMP_EN defined:
//   - Adds a 16-bit free-running TickCount (incremented on each Tick, wraps 0xFFFF->0, reset 0).
//   - Adds output port EventTime[15:0], carried in every FIFO entry with the TickCount at push.
//  DEBOUNCE_TIMESTAMP_EN undefined:
//   - No counter and no EventTime port.
//   - FIFO entry holds {channel, rise} only.
//   - All other behaviour is identical.
// STRUCTURE
//  Package debounce_pkg:
//   - scan_state_t enum {IDLE, SCAN}.
//   - event_t packed struct {channel, rise[, time]}.
//   - localparam function prescale().
//  Sub-module debounce_event_fifo: single-clock FIFO of event_t with push/full and valid/ready pop.
//  Top holds the prescaler, FSM, the history array (CHANNELS x DEPTH) and the O register.
// TESTING
//  1. Release reset, all I=1 -> O='1, EventValid=0, no events after 10 ticks.
//  2. I[3]: 1->0 held, DEPTH=4 -> O[3] falls on the 4th scan of ch3 (one clock after its SCAN visit);
//     one event {3, fall}.
//  3. I[5] toggling every tick -> O[5] stays 1, no events; then hold 1 -> still none.
//  4. EventReady=0; force 9 edges with FIFO_DEPTH=8 -> 8 stored in channel order, Overflow=1;
//     pop all -> same order; ClearOverflow -> 0.
//  5. FIFO full, push and pop in the same cycle -> no drop, Overflow stays 0.
//  6. Assert nReset mid-scan with 3 events queued -> EventValid=0 and O='1 asynchronously.
//     With DEBOUNCE_TIMESTAMP_EN, the next event after reset has EventTime equal to the tick count since reset.

Source files
------------

// File: rtl/debounce_scan_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_pkg
//  Description : Shared types and helpers for the time-shared debounce engine.
//                DEBOUNCE_TIMESTAMP_EN adds a 16-bit tick stamp to each event.
//  Revision    : 1.0 - initial release
// ============================================================================
package debounce_pkg;

    // Event channel field is sized for the largest supported channel count (32).
    localparam int c_MAX_CH_W = 5;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

    typedef struct packed {
        logic [c_MAX_CH_W-1:0] channel;
        logic                  rise;
`ifdef DEBOUNCE_TIMESTAMP_EN
        logic [15:0]           tstamp;
`endif
    } event_t;

    // Clocks between scan ticks so DEPTH equal samples span the filter period.
    function automatic int prescale(input int filter_ns, input int clock_ns, input int depth);
        return filter_ns / clock_ns / (depth - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_scan_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_scan_controller_if
//  Description : Host-facing bundle: raw inputs, debounced levels, event
//                stream (valid/ready) and overflow status.
//                DEBOUNCE_TIMESTAMP_EN adds EventTime.
//  Revision    : 1.0 - initial release
// ============================================================================
interface debounce_scan_controller_if #(
    parameter int CHANNELS = 8
);
    localparam int c_CH_W = $clog2(CHANNELS);

    logic                Enable;
    logic [CHANNELS-1:0] I;
    logic [CHANNELS-1:0] O;
    logic                EventValid;
    logic                EventReady;
    logic [c_CH_W-1:0]   EventChannel;
    logic                EventRise;
    logic                Overflow;
    logic                ClearOverflow;
`ifdef DEBOUNCE_TIMESTAMP_EN
    logic [15:0]         EventTime;
`endif

    modport slave (
        input  Enable, I, EventReady, ClearOverflow,
        output O, EventValid, EventChannel, EventRise, Overflow
`ifdef DEBOUNCE_TIMESTAMP_EN
        , output EventTime
`endif
    );

    modport master (
        output Enable, I, EventReady, ClearOverflow,
        input  O, EventValid, EventChannel, EventRise, Overflow
`ifdef DEBOUNCE_TIMESTAMP_EN
        , input EventTime
`endif
    );

endinterface
`default_nettype wire

// File: rtl/debounce_scan_controller_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_event_fifo
//  Description : Single-clock event FIFO, push side with drop indication,
//                valid/ready pop side. A push into a full FIFO that is being
//                popped in the same cycle is accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_event_fifo
    import debounce_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  wire logic   Clock,
    input  wire logic   nReset,
    input  wire logic   push_i,
    input  wire event_t push_data_i,
    output logic        drop_o,
    output logic        pop_valid_o,
    input  wire logic   pop_ready_i,
    output event_t      pop_data_o
);
    localparam int c_AW = $clog2(FIFO_DEPTH);

    if ((FIFO_DEPTH < 2) || ((1 << c_AW) != FIFO_DEPTH)) begin : g_depth_check
        $error("FIFO_DEPTH must be a power of two >= 2");
    end

    event_t          mem_q [FIFO_DEPTH];
    logic [c_AW:0]   wr_ptr_q, wr_ptr_d;
    logic [c_AW:0]   rd_ptr_q, rd_ptr_d;
    logic            empty, full, pop, push_ok;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[c_AW] != rd_ptr_q[c_AW]) &&
                     (wr_ptr_q[c_AW-1:0] == rd_ptr_q[c_AW-1:0]);
    assign pop     = !empty && pop_ready_i;
    assign push_ok = push_i && (!full || pop);

    assign drop_o      = push_i && full && !pop;
    assign pop_valid_o = !empty;
    assign pop_data_o  = mem_q[rd_ptr_q[c_AW-1:0]];

    // Pointer next-state; the extra MSB separates full from empty.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Pointer registers.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage; contents are qualified by the pointers so no reset is needed.
    always_ff @(posedge Clock) begin
        if (push_ok) mem_q[wr_ptr_q[c_AW-1:0]] <= push_data_i;
    end

endmodule
`default_nettype wire

// File: rtl/debounce_scan_controller.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_scan_controller
//  Description : Time-shared debouncer. A prescaler tick starts a scan pass
//                that visits one channel per clock, shifts its history and
//                pushes level changes as events into a FIFO.
//                Optional macro DEBOUNCE_TIMESTAMP_EN stamps each event with a
//                16-bit tick count.
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_scan_controller
    import debounce_pkg::*;
#(
    parameter int CHANNELS         = 8,
    parameter int DEPTH            = 4,
    parameter int CLOCK_PERIOD_NS  = 20,
    parameter int FILTER_PERIOD_NS = 500_000,
    parameter int FIFO_DEPTH       = 8
) (
    input  wire logic                  Clock,
    input  wire logic                  nReset,
    debounce_scan_controller_if.slave  bus
);
    localparam int c_PRESCALE = prescale(FILTER_PERIOD_NS, CLOCK_PERIOD_NS, DEPTH);
    localparam int c_CH_W     = $clog2(CHANNELS);
    localparam int c_PS_W     = $clog2(c_PRESCALE);

    // A tick must never land inside a scan pass.
    if ((c_PRESCALE <= CHANNELS) || (DEPTH < 2) || (CHANNELS < 2) || (CHANNELS > 32))
    begin : g_param_check
        $error("Invalid parameters: need PRESCALE > CHANNELS, DEPTH >= 2, 2 <= CHANNELS <= 32");
    end

    logic [c_PS_W-1:0]   ps_q, ps_d;
    logic                tick;
    scan_state_t         state_q, state_d;
    logic [c_CH_W-1:0]   ch_q, ch_d;
    logic                visit;
    logic [DEPTH-1:0]    hist_q [CHANNELS];
    logic [CHANNELS-1:0] level_q;
    logic [DEPTH-1:0]    hnew;
    logic                fall_edge, rise_edge, push, drop;
    logic                overflow_q;
    logic                event_valid;
    event_t              push_data, head;
    logic                unused_head;

    // Prescaler next-state: free count while enabled, frozen otherwise.
    always_comb begin
        ps_d = ps_q;
        tick = 1'b0;
        if (bus.Enable) begin
            if (ps_q == c_PS_W'(c_PRESCALE - 1)) begin
                ps_d = '0;
                tick = 1'b1;
            end else begin
                ps_d = ps_q + 1'b1;
            end
        end
    end

    // Prescaler and scan FSM state registers.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            ps_q    <= '0;
            state_q <= IDLE;
            ch_q    <= '0;
        end else begin
            ps_q    <= ps_d;
            state_q <= state_d;
            ch_q    <= ch_d;
        end
    end

    // Scan FSM: a tick starts a pass that runs to the last channel regardless of Enable.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        visit   = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = SCAN;
                    ch_d    = '0;
                end
            end
            SCAN: begin
                visit = 1'b1;
                if (ch_q == c_CH_W'(CHANNELS - 1)) state_d = IDLE;
                else                                ch_d    = ch_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign hnew      = {hist_q[ch_q][DEPTH-2:0], bus.I[ch_q]};
    assign fall_edge = visit && (hnew == '0) &&  level_q[ch_q];
    assign rise_edge = visit && (&hnew)      && !level_q[ch_q];
    assign push      = fall_edge || rise_edge;

    // History and debounced level of the visited channel; level follows DEPTH equal samples.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            for (int k = 0; k < CHANNELS; k++) hist_q[k] <= '1;
            level_q <= '1;
        end else if (visit) begin
            hist_q[ch_q] <= hnew;
            if (fall_edge) level_q[ch_q] <= 1'b0;
            if (rise_edge) level_q[ch_q] <= 1'b1;
        end
    end

`ifdef DEBOUNCE_TIMESTAMP_EN
    logic [15:0] tick_count_q;

    // Free-running tick counter that stamps each event.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset)   tick_count_q <= '0;
        else if (tick) tick_count_q <= tick_count_q + 16'd1;
    end
`endif

    // Event record for the visited channel.
    always_comb begin
        push_data         = '0;
        push_data.channel = c_MAX_CH_W'(ch_q);
        push_data.rise    = rise_edge;
`ifdef DEBOUNCE_TIMESTAMP_EN
        push_data.tstamp  = tick_count_q;
`endif
    end

    debounce_event_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .Clock       (Clock),
        .nReset      (nReset),
        .push_i      (push),
        .push_data_i (push_data),
        .drop_o      (drop),
        .pop_valid_o (event_valid),
        .pop_ready_i (bus.EventReady),
        .pop_data_o  (head)
    );

    // Sticky overflow; a drop in the same cycle wins over a clear.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset)                overflow_q <= 1'b0;
        else if (drop)              overflow_q <= 1'b1;
        else if (bus.ClearOverflow) overflow_q <= 1'b0;
    end

    // Upper channel bits beyond c_CH_W are always zero.
    assign unused_head = ^head.channel;

    assign bus.O            = level_q;
    assign bus.EventValid   = event_valid;
    assign bus.EventChannel = head.channel[c_CH_W-1:0];
    assign bus.EventRise    = head.rise;
    assign bus.Overflow     = overflow_q;
`ifdef DEBOUNCE_TIMESTAMP_EN
    assign bus.EventTime    = head.tstamp;
`endif

endmodule
`default_nettype wire

// File: tb/tb_debounce_scan_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_debounce_scan_controller
//  Description : Directed self-checking bench. PRESCALE is 12, so channel c of
//                scan pass p is visited on clock edge 12*p+1+c after reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_debounce_scan_controller;

    localparam int c_CH    = 8;
    localparam int c_DEPTH = 4;
    localparam int c_CLK   = 20;
    localparam int c_FILT  = 720;   // 720/20/3 = 12 clocks per tick
    localparam int c_FIFO  = 8;

    logic Clock  = 1'b0;
    logic nReset = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;

    debounce_scan_controller_if #(.CHANNELS(c_CH)) bus_if ();

    debounce_scan_controller #(
        .CHANNELS         (c_CH),
        .DEPTH            (c_DEPTH),
        .CLOCK_PERIOD_NS  (c_CLK),
        .FILTER_PERIOD_NS (c_FILT),
        .FIFO_DEPTH       (c_FIFO)
    ) dut (
        .Clock  (Clock),
        .nReset (nReset),
        .bus    (bus_if)
    );

    always #5 Clock = ~Clock;

    // Advance to 1 ns after edge number 'target'.
    task automatic run_to(input int target);
        while (cyc < target) begin
            @(posedge Clock);
            #1;
            cyc++;
        end
    endtask

    // Advance to just after a pass ends (edge 12*q+9).
    task automatic align();
        run_to(cyc + ((21 - (cyc % 12)) % 12));
    endtask

    task automatic pop_one();
        bus_if.EventReady = 1'b1;
        run_to(cyc + 1);
        bus_if.EventReady = 1'b0;
    endtask

    task automatic test_reset();
        bit seen;
        repeat (3) @(posedge Clock);
        #1;
        vectors++;
        if (bus_if.O !== 8'hFF) begin
            miscompares++; $display("FAIL reset_O: got %h want ff", bus_if.O);
        end
        vectors++;
        if (bus_if.EventValid !== 1'b0) begin
            miscompares++; $display("FAIL reset_valid: got %b want 0", bus_if.EventValid);
        end
        vectors++;
        if (bus_if.Overflow !== 1'b0) begin
            miscompares++; $display("FAIL reset_overflow: got %b want 0", bus_if.Overflow);
        end
        nReset = 1'b1;
        cyc    = 0;
        seen   = 1'b0;
        for (int k = 0; k < 120; k++) begin
            run_to(cyc + 1);
            if (bus_if.EventValid !== 1'b0) seen = 1'b1;
        end
        vectors++;
        if (seen || bus_if.O !== 8'hFF) begin
            miscompares++; $display("FAIL idle_ticks: event_seen=%b O=%h want 0/ff", seen, bus_if.O);
        end
    endtask

    task automatic test_debounce_fall();
        bus_if.I[3] = 1'b0;               // sampled from pass 10 (edge 124)
        run_to(159);
        vectors++;
        if (bus_if.O[3] !== 1'b1 || bus_if.EventValid !== 1'b0) begin
            miscompares++; $display("FAIL fall_early: O3=%b valid=%b want 1/0", bus_if.O[3], bus_if.EventValid);
        end
        run_to(160);                       // 4th zero sample of ch3
        vectors++;
        if (bus_if.O[3] !== 1'b0 || bus_if.EventValid !== 1'b1 ||
            bus_if.EventChannel !== 3'd3 || bus_if.EventRise !== 1'b0) begin
            miscompares++;
            $display("FAIL fall_event: O3=%b valid=%b ch=%0d rise=%b want 0/1/3/0",
                     bus_if.O[3], bus_if.EventValid, bus_if.EventChannel, bus_if.EventRise);
        end
        pop_one();
        vectors++;
        if (bus_if.EventValid !== 1'b0) begin
            miscompares++; $display("FAIL fall_pop: valid=%b want 0", bus_if.EventValid);
        end
    endtask

    task automatic test_bounce();
        for (int k = 0; k < 8; k++) begin
            bus_if.I[5] = ~bus_if.I[5];
            run_to(cyc + 12);
            vectors++;
            if (bus_if.EventValid !== 1'b0 || bus_if.O[5] !== 1'b1) begin
                miscompares++;
                $display("FAIL bounce_%0d: valid=%b O5=%b want 0/1", k, bus_if.EventValid, bus_if.O[5]);
            end
        end
        bus_if.I[5] = 1'b1;
        run_to(cyc + 60);
        vectors++;
        if (bus_if.EventValid !== 1'b0 || bus_if.O !== 8'hF7) begin
            miscompares++; $display("FAIL bounce_hold: valid=%b O=%h want 0/f7", bus_if.EventValid, bus_if.O);
        end
    endtask

    task automatic test_overflow();
        int p0;
        align();
        p0 = (cyc - 9) / 12 + 1;
        bus_if.I = 8'h08;                  // 7 falls + ch3 rise, all in pass p0+3
        run_to(12 * (p0 + 3) + 9);
        vectors++;
        if (bus_if.EventValid !== 1'b1 || bus_if.Overflow !== 1'b0 || bus_if.O !== 8'h08) begin
            miscompares++;
            $display("FAIL ovf_fill: valid=%b ovf=%b O=%h want 1/0/08", bus_if.EventValid, bus_if.Overflow, bus_if.O);
        end
        bus_if.I[0] = 1'b1;                // 9th event at edge 12*(p0+7)+1
        run_to(12 * (p0 + 7));
        vectors++;
        if (bus_if.Overflow !== 1'b0) begin
            miscompares++; $display("FAIL ovf_early: ovf=%b want 0", bus_if.Overflow);
        end
        run_to(12 * (p0 + 7) + 1);
        vectors++;
        if (bus_if.Overflow !== 1'b1 || bus_if.O !== 8'h09) begin
            miscompares++; $display("FAIL ovf_drop: ovf=%b O=%h want 1/09", bus_if.Overflow, bus_if.O);
        end
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (bus_if.EventValid !== 1'b1 || bus_if.EventChannel !== 3'(k) || bus_if.EventRise !== (k == 3)) begin
                miscompares++;
                $display("FAIL ovf_pop_%0d: valid=%b ch=%0d rise=%b want 1/%0d/%b",
                         k, bus_if.EventValid, bus_if.EventChannel, bus_if.EventRise, k, (k == 3));
            end
            pop_one();
        end
        vectors++;
        if (bus_if.EventValid !== 1'b0 || bus_if.Overflow !== 1'b1) begin
            miscompares++; $display("FAIL ovf_drained: valid=%b ovf=%b want 0/1", bus_if.EventValid, bus_if.Overflow);
        end
        bus_if.ClearOverflow = 1'b1;
        run_to(cyc + 1);
        bus_if.ClearOverflow = 1'b0;
        vectors++;
        if (bus_if.Overflow !== 1'b0) begin
            miscompares++; $display("FAIL ovf_clear: ovf=%b want 0", bus_if.Overflow);
        end
    endtask

    task automatic test_push_pop_full();
        int     p0;
        logic [2:0] exp_ch [8];
        logic       exp_r  [8];
        exp_ch = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1};
        exp_r  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        align();
        p0 = (cyc - 9) / 12 + 1;
        bus_if.I = 8'hF6;                  // ch0 fall, ch3 fall, others rise
        run_to(12 * (p0 + 3) + 9);
        bus_if.I[1] = 1'b0;                // ch1 fall at edge 12*(p0+7)+2
        run_to(12 * (p0 + 7) + 1);
        bus_if.EventReady = 1'b1;
        run_to(12 * (p0 + 7) + 2);
        bus_if.EventReady = 1'b0;
        vectors++;
        if (bus_if.Overflow !== 1'b0 || bus_if.O !== 8'hF4) begin
            miscompares++; $display("FAIL full_pushpop: ovf=%b O=%h want 0/f4", bus_if.Overflow, bus_if.O);
        end
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (bus_if.EventValid !== 1'b1 || bus_if.EventChannel !== exp_ch[k] || bus_if.EventRise !== exp_r[k]) begin
                miscompares++;
                $display("FAIL full_pop_%0d: valid=%b ch=%0d rise=%b want 1/%0d/%b",
                         k, bus_if.EventValid, bus_if.EventChannel, bus_if.EventRise, exp_ch[k], exp_r[k]);
            end
            pop_one();
        end
        vectors++;
        if (bus_if.EventValid !== 1'b0) begin
            miscompares++; $display("FAIL full_drained: valid=%b want 0", bus_if.EventValid);
        end
    endtask

    task automatic test_reset_mid_scan();
        int p0;
        align();
        p0 = (cyc - 9) / 12 + 1;
        bus_if.I = 8'h14;                  // ch5, ch6, ch7 fall
        run_to(12 * (p0 + 3) + 9);
        vectors++;
        if (bus_if.EventValid !== 1'b1 || bus_if.EventChannel !== 3'd5 || bus_if.EventRise !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_queued: valid=%b ch=%0d rise=%b want 1/5/0",
                     bus_if.EventValid, bus_if.EventChannel, bus_if.EventRise);
        end
        run_to(12 * (p0 + 4) + 4);         // mid-scan
        nReset = 1'b0;
        #1;
        vectors++;
        if (bus_if.EventValid !== 1'b0 || bus_if.O !== 8'hFF || bus_if.Overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_async: valid=%b O=%h ovf=%b want 0/ff/0", bus_if.EventValid, bus_if.O, bus_if.Overflow);
        end
        @(posedge Clock);
        #1;
        nReset = 1'b1;
        cyc    = 0;
        run_to(48);                        // inputs 0,1,3,5,6,7 low: 4th sample in pass 4
        vectors++;
        if (bus_if.EventValid !== 1'b0 || bus_if.O !== 8'hFF) begin
            miscompares++; $display("FAIL rst_rescan_early: valid=%b O=%h want 0/ff", bus_if.EventValid, bus_if.O);
        end
        run_to(49);
        vectors++;
        if (bus_if.EventValid !== 1'b1 || bus_if.EventChannel !== 3'd0 || bus_if.EventRise !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_rescan: valid=%b ch=%0d rise=%b want 1/0/0",
                     bus_if.EventValid, bus_if.EventChannel, bus_if.EventRise);
        end
    endtask

    initial begin
        bus_if.Enable        = 1'b1;
        bus_if.I             = 8'hFF;
        bus_if.EventReady    = 1'b0;
        bus_if.ClearOverflow = 1'b0;
        test_reset();
        test_debounce_fall();
        test_bounce();
        test_overflow();
        test_push_pop_full();
        test_reset_mid_scan();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
